// File: rtl/ccd_line_capture.sv
// CCD receive path: tracks line/column position, estimates optical-black per line,
// windows the active area, subtracts black and streams pixels out through a small FIFO.
module ccd_line_capture #(
    parameter int H_START     = 40,
    parameter int H_ACTIVE    = 1360,
    parameter int V_START     = 8,
    parameter int V_ACTIVE    = 1024,
    parameter int OB_LOG2     = 4,
    parameter int SUBTRACT_OB = 1,
    parameter int FIFO_LOG2   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        hblank,
    input  logic        cob,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sol,
    output logic        pix_eof,
    output logic [15:0] ob_level,
    output logic [10:0] line_count,
    output logic        overflow,
    output logic        busy
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [11:0]        COL_FIRST  = 12'(H_START);
    localparam logic [11:0]        COL_LAST   = 12'(H_START + H_ACTIVE - 1);
    localparam logic [10:0]        LINE_FIRST = 11'(V_START);
    localparam logic [10:0]        LINE_LAST  = 11'(V_START + V_ACTIVE - 1);
    localparam logic [OB_LOG2:0]   OB_FULL    = (OB_LOG2 + 1)'(1 << OB_LOG2);
    localparam logic [FIFO_LOG2:0] FIFO_FULL  = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, IN_LINE, DONE} state_t;

    state_t             state;
    logic               hblank_q;
    logic               cob_q;
    logic [11:0]        col;
    logic [10:0]        cur_line;
    logic [21:0]        ob_sum;
    logic [OB_LOG2:0]   ob_cnt;

    logic hb_fall, hb_rise, cob_fall, pixel_active;

    assign hb_fall  = hblank_q & ~hblank;
    assign hb_rise  = ~hblank_q & hblank;
    assign cob_fall = cob_q & ~cob;
    assign busy     = (state == WAIT_LINE) || (state == IN_LINE);

    assign pixel_active = (state == IN_LINE) && adc_valid && !cob &&
                          (col >= COL_FIRST) && (col <= COL_LAST) &&
                          (cur_line >= LINE_FIRST) && (cur_line <= LINE_LAST);

    // Line/frame sequencing plus the black-level accumulator, which restarts every line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hblank_q   <= 1'b0;
            cob_q      <= 1'b0;
            col        <= 12'd0;
            cur_line   <= 11'd0;
            line_count <= 11'd0;
            ob_sum     <= 22'd0;
            ob_cnt     <= '0;
            ob_level   <= 16'd0;
        end else begin
            hblank_q <= hblank;
            cob_q    <= cob;
            if (frame_start) begin
                line_count <= 11'd0;
                state      <= WAIT_LINE;
            end else begin
                case (state)
                    WAIT_LINE: begin
                        if (hb_fall) begin
                            state      <= IN_LINE;
                            col        <= 12'd0;
                            cur_line   <= line_count;
                            line_count <= line_count + 11'd1;
                            ob_sum     <= 22'd0;
                            ob_cnt     <= '0;
                        end
                    end
                    IN_LINE: begin
                        if (adc_valid && col != 12'hFFF)
                            col <= col + 12'd1;
                        if (adc_valid && cob && ob_cnt != OB_FULL) begin
                            ob_sum <= ob_sum + 22'(adc_data);
                            ob_cnt <= ob_cnt + (OB_LOG2 + 1)'(1);
                        end
                        if (hb_rise)
                            state <= (cur_line == LINE_LAST) ? DONE : WAIT_LINE;
                    end
                    default: ;
                endcase
            end
            // A short clamp window leaves the previous estimate in place.
            if (cob_fall && ob_cnt == OB_FULL)
                ob_level <= 16'(ob_sum >> OB_LOG2);
        end
    end

    logic        s1_valid, s1_sol, s1_eof;
    logic [15:0] s1_data, s1_ob, s2_data;

    always_ff @(posedge clk) begin
        if (reset || frame_start)
            s1_valid <= 1'b0;
        else
            s1_valid <= pixel_active;
    end

    always_ff @(posedge clk) begin
        if (pixel_active) begin
            s1_data <= adc_data;
            s1_ob   <= ob_level;
            s1_sol  <= (col == COL_FIRST);
            s1_eof  <= (col == COL_LAST) && (cur_line == LINE_LAST);
        end
    end

    always_comb begin
        s2_data = s1_data;
        if (SUBTRACT_OB != 0)
            s2_data = (s1_data > s1_ob) ? (s1_data - s1_ob) : 16'd0;
    end

    logic [17:0]          mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 fifo_full, rd_en, wr_en;
    logic [17:0]          head;

    assign fifo_full = (count == FIFO_FULL);
    assign pix_valid = (count != '0);
    assign rd_en     = pix_valid && pix_ready;
    // The head slot is read combinationally before this edge, so a full FIFO may write while reading.
    assign wr_en     = s1_valid && (!fifo_full || rd_en);
    assign head      = mem[rd_ptr];
    assign pix_data  = head[15:0];
    assign pix_sol   = pix_valid & head[16];
    assign pix_eof   = pix_valid & head[17];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s1_eof, s1_sol, s2_data};
    end

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (FIFO_LOG2 + 1)'(1);
                2'b01:   count <= count - (FIFO_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            if (s1_valid && fifo_full && !rd_en)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccd_line_capture.sv
// Scoreboard bench for ccd_line_capture: directed lines push expected pixels,
// a negedge monitor pops and compares every accepted output beat.
module tb_ccd_line_capture;

    localparam int H_START = 4, H_ACTIVE = 8, V_START = 1, V_ACTIVE = 2;
    localparam int OB_LOG2 = 2, SUBTRACT_OB = 1, FIFO_LOG2 = 2;

    logic        clk;
    logic        reset, frame_start, hblank, cob, adc_valid, pix_ready;
    logic [15:0] adc_data, pix_data, ob_level;
    logic        pix_valid, pix_sol, pix_eof, overflow, busy;
    logic [10:0] line_count;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] expq[$];
    logic [17:0] expv;

    ccd_line_capture #(
        .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
        .OB_LOG2(OB_LOG2), .SUBTRACT_OB(SUBTRACT_OB), .FIFO_LOG2(FIFO_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .hblank(hblank), .cob(cob),
        .adc_data(adc_data), .adc_valid(adc_valid), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_sol(pix_sol), .pix_eof(pix_eof), .ob_level(ob_level),
        .line_count(line_count), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic c, input logic [15:0] d);
        adc_valid = v;
        cob       = c;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic expectPixel(input logic eof, input logic sol, input logic [15:0] d);
        expq.push_back({eof, sol, d});
    endtask

    task automatic lineStart();
        hblank = 1'b0;
        tick();
    endtask

    task automatic lineEnd();
        hblank = 1'b1;
        tick();
        tick();
    endtask

    task automatic frameStart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pixel: got data %0d sol %0b eof %0b, expected no pixel",
                         pix_data, pix_sol, pix_eof);
            end else begin
                expv = expq.pop_front();
                if ({pix_eof, pix_sol, pix_data} !== expv) begin
                    errors++;
                    $display("[TB] FAIL pixel: got data %0d sol %0b eof %0b, expected data %0d sol %0b eof %0b",
                             pix_data, pix_sol, pix_eof, expv[15:0], expv[16], expv[17]);
                end
            end
        end
    end

    logic [15:0] line2In  [8] = '{16'd30, 16'd10, 16'd40, 16'd41, 16'd42, 16'd43, 16'd44, 16'd45};
    logic [15:0] line2Out [8] = '{16'd7,  16'd0,  16'd17, 16'd18, 16'd19, 16'd20, 16'd21, 16'd22};

    initial begin
        reset = 1'b1; frame_start = 1'b0; hblank = 1'b1; cob = 1'b0;
        adc_data = 16'd0; adc_valid = 1'b0; pix_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_pix_valid", 32'(pix_valid), 0);
        checkOutput("reset_pix_sol", 32'(pix_sol), 0);
        checkOutput("reset_pix_eof", 32'(pix_eof), 0);
        checkOutput("reset_ob_level", 32'(ob_level), 0);
        checkOutput("reset_line_count", 32'(line_count), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);
        checkOutput("reset_busy", 32'(busy), 0);

        pix_ready = 1'b1;
        frameStart();
        checkOutput("frame_busy", 32'(busy), 1);

        // Line 0 lies above the active window.
        lineStart();
        checkOutput("line0_count", 32'(line_count), 1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 16'(200 + i));
        lineEnd();

        lineStart();
        checkOutput("line1_count", 32'(line_count), 2);
        for (int i = 0; i < 16; i++) begin
            if (i >= 4 && i <= 11) expectPixel(1'b0, i == 4, 16'(100 + i));
            applyStimulus(1'b1, 1'b0, 16'(100 + i));
            if (i == 4) checkOutput("latency_not_early", 32'(pix_valid), 0);
            if (i == 5) checkOutput("latency_two_cycles", 32'(pix_valid), 1);
        end
        lineEnd();
        checkOutput("between_lines_busy", 32'(busy), 1);

        // Last active line: clamp window then black-subtracted pixels with eof at the end.
        lineStart();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(20 + 2 * i));
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("ob_level_avg", 32'(ob_level), 23);
        for (int k = 0; k < 8; k++) begin
            expectPixel(k == 7, k == 0, line2Out[k]);
            applyStimulus(1'b1, 1'b0, line2In[k]);
        end
        applyStimulus(1'b1, 1'b0, 16'd50);
        applyStimulus(1'b1, 1'b0, 16'd51);
        lineEnd();
        checkOutput("done_busy", 32'(busy), 0);
        checkOutput("done_line_count", 32'(line_count), 3);

        lineStart();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 16'(400 + i));
        lineEnd();
        checkOutput("done_ignores_lines", 32'(line_count), 3);
        checkOutput("done_still_idle", 32'(busy), 0);

        frameStart();
        checkOutput("frame2_line_count", 32'(line_count), 0);
        checkOutput("frame2_ob_kept", 32'(ob_level), 23);

        lineStart();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'd5);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("ob_short_window_kept", 32'(ob_level), 23);
        for (int i = 3; i < 16; i++) applyStimulus(1'b1, 1'b0, 16'(i));
        lineEnd();

        // Stalled output: four pixels fit, the next two are dropped.
        pix_ready = 1'b0;
        lineStart();
        for (int i = 0; i < 10; i++) begin
            if (i >= 4 && i <= 7) expectPixel(1'b0, i == 4, 16'(33 + i));
            applyStimulus(1'b1, 1'b0, 16'(56 + i));
        end
        lineEnd();
        checkOutput("overflow_set", 32'(overflow), 1);
        checkOutput("stall_valid", 32'(pix_valid), 1);
        checkOutput("stall_data", 32'(pix_data), 37);
        checkOutput("stall_sol", 32'(pix_sol), 1);
        repeat (3) tick();
        checkOutput("stall_data_held", 32'(pix_data), 37);
        checkOutput("stall_sol_held", 32'(pix_sol), 1);
        pix_ready = 1'b1;
        repeat (6) tick();
        checkOutput("drained", 32'(pix_valid), 0);
        frameStart();
        checkOutput("overflow_cleared", 32'(overflow), 0);

        lineStart();
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'(i));
        lineEnd();

        // Reset in the middle of an active line with two pixels waiting.
        pix_ready = 1'b0;
        lineStart();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'(70 + i));
        tick();
        checkOutput("pre_reset_valid", 32'(pix_valid), 1);
        reset = 1'b1;
        tick();
        checkOutput("midline_reset_valid", 32'(pix_valid), 0);
        checkOutput("midline_reset_line_count", 32'(line_count), 0);
        checkOutput("midline_reset_busy", 32'(busy), 0);
        checkOutput("midline_reset_ob", 32'(ob_level), 0);
        reset = 1'b0;
        pix_ready = 1'b1;
        hblank = 1'b1;
        tick();
        lineStart();
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'(500 + i));
        lineEnd();
        checkOutput("idle_ignores_line", 32'(line_count), 0);
        checkOutput("idle_busy", 32'(busy), 0);

        frameStart();
        lineStart();
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'(i));
        lineEnd();
        lineStart();
        for (int i = 0; i < 12; i++) begin
            if (i >= 4) expectPixel(1'b0, i == 4, 16'(300 + i));
            applyStimulus(1'b1, 1'b0, 16'(300 + i));
        end
        lineEnd();
        repeat (10) tick();
        checkOutput("scoreboard_empty", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_line_capture.md
Name: ccd_line_capture

Overview:
- Receive end of the CCD readout path: consumes digitised samples from the analog front end, timed by the same hblank / optical-black clamp windows the CCD timing generator drives.
- Tracks column/line position, estimates the per-line optical-black level, windows the active pixel area, and subtracts black.
- Buffers active pixels in a small FIFO and emits them on a valid/ready stream with start-of-line / end-of-frame tags.

Parameters:
- H_START, 40, sample index within a line (0-based, counted after hblank falls) of the first active pixel
- H_ACTIVE, 1360, active pixels per line
- V_START, 8, line index (0-based after frame_start) of the first active line
- V_ACTIVE, 1024, active lines per frame
- OB_LOG2, 4, log2 of black samples averaged per line (16)
- SUBTRACT_OB, 1, 1 = output max(sample - ob_level, 0); 0 = raw sample
- FIFO_LOG2, 4, log2 FIFO depth (16)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; starts a new frame
- hblank  in  1  high during horizontal blanking; falling edge starts a line, rising edge ends it
- cob  in  1  high while optical-black clamp samples are on adc_data
- adc_data  in  16  front-end sample
- adc_valid  in  1  adc_data valid this cycle
- pix_data  out  16  output pixel
- pix_valid  out  1  pix_data/tags valid
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready
- pix_sol  out  1  first active pixel of a line
- pix_eof  out  1  last active pixel of the frame
- ob_level  out  16  current black estimate
- line_count  out  11  lines started since frame_start
- overflow  out  1  sticky: a sample was dropped on a full FIFO
- busy  out  1  frame capture in progress

Behaviour:
- Reset: state IDLE; FIFO emptied; pix_valid=0, pix_sol=0, pix_eof=0, ob_level=0, line_count=0, overflow=0, busy=0. Reset overrides every other input on the same edge, including mid-line.
- States: IDLE, WAIT_LINE, IN_LINE, DONE. busy=1 in WAIT_LINE/IN_LINE.
- frame_start in any state: line_count=0, FIFO flushed, overflow=0, enter WAIT_LINE. ob_level is kept.
- WAIT_LINE: a 1->0 transition of hblank (previous-cycle register) enters IN_LINE and sets col=0. The line index is line_count; line_count increments on the same edge.
- IN_LINE: each adc_valid increments col (12 bits, saturates at 4095). A 0->1 transition of hblank returns to WAIT_LINE. If the line just ended was line V_START+V_ACTIVE-1, go to DONE instead. Short lines are truncated with no error.
- DONE: no capture. Hold until frame_start. Later hblank edges are ignored.
- Black level:
  - In IN_LINE, while cob=1 and adc_valid=1, accumulate the first 2^OB_LOG2 samples (22-bit sum) and count them.
  - On the cob 1->0 edge, if count == 2^OB_LOG2, then ob_level <= sum >> OB_LOG2. Otherwise ob_level is unchanged.
  - Sum and count clear at each line start.
  - A sample with cob=1 is never an active pixel.
- Active pixel: IN_LINE, adc_valid=1, cob=0, H_START <= col < H_START+H_ACTIVE, and V_START <= line < V_START+V_ACTIVE (col = value before increment).
- Pipeline:
  - Stage 1 registers the sample and tags: sol = (col==H_START); eof = (col==H_START+H_ACTIVE-1 and line==V_START+V_ACTIVE-1).
  - Stage 2 computes the subtraction (clamped at 0, using ob_level sampled in stage 1) and writes the FIFO.
  - FIFO is show-ahead. With an empty FIFO, pix_valid rises exactly 2 cycles after the adc_valid cycle.
- FIFO: stores 18 bits {eof, sol, data}. Simultaneous write and read are allowed at every fill level, including full. A write to a full FIFO with no read that cycle is dropped and sets overflow=1. Order is preserved.
- Stream: pix_data/pix_sol/pix_eof stay stable while pix_valid=1 and pix_ready=0.

Test Plan (H_START=4, H_ACTIVE=8, V_START=1, V_ACTIVE=2, OB_LOG2=2, FIFO_LOG2=2):
- Reset, then frame_start. Line 0 has 16 samples, line 1 has samples 100..115 -> line 0 produces nothing. Line 1 outputs 104..111 with pix_sol on 104. First pix_valid comes 2 cycles after the 104 sample.
- cob high for samples 20,22,24,26 then low, SUBTRACT_OB=1 -> ob_level=23. A following active sample of 30 outputs 7; a sample of 10 outputs 0.
- cob window with only 3 samples -> ob_level keeps its previous value.
- pix_ready=0 across 6 active samples -> the first 4 are held, the last 2 are dropped, and overflow=1. Raising ready yields exactly 4 pixels in order. A later frame_start clears overflow.
- Full frame with lines 1 and 2 active -> the last pixel of line 2 has pix_eof=1. State goes to DONE, busy=0, and further lines produce no output.
- reset asserted mid-line with 2 pixels in the FIFO -> next cycle pix_valid=0, line_count=0, state IDLE. Samples are ignored until frame_start.
